// File: rtl/gcore_pkg.sv
// gcore_pkg: shared opcode-memory widths and sequencer state encoding.
package gcore_pkg;
    localparam int OPMEM_ADDR_W = 3;
    localparam int OPMEM_DATA_W = 8;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RD_REQ, ST_RD_WAIT, ST_HOLD} opmem_seq_state_t;
endpackage

// File: rtl/opmem_seq.sv
// opmem_seq: loads a byte stream into the opcode memory and replays it over a valid/ready port.
module opmem_seq
    import gcore_pkg::*;
#(
    parameter int ADDR_W = OPMEM_ADDR_W,
    parameter int DATA_W = OPMEM_DATA_W,
    parameter bit LOOP   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              run_start,
    input  logic              abort,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_data,
    output logic              op_last,
    input  logic              op_ready,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(2**ADDR_W);

    opmem_seq_state_t  state;
    logic [ADDR_W-1:0] ptr;
    logic              in_load;
    logic              wr_fire;
    logic [ADDR_W:0]   count_nx;

    assign in_load  = state == ST_LOAD;
    assign wr_fire  = in_load && wr_valid;
    assign count_nx = (count == FULL) ? count : count + 1'b1;
    assign wr_ready = in_load;
    assign busy     = state != ST_IDLE;
    assign mem_oce  = 1'b1;
    assign mem_ce   = wr_fire || state == ST_RD_REQ;
    assign mem_wre  = wr_fire;
    assign mem_ad   = ptr;
    assign mem_din  = in_load ? wr_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            count    <= '0;
            op_valid <= 1'b0;
            op_data  <= '0;
            op_last  <= 1'b0;
        end else begin
            // a write accepted alongside abort still lands, so its bookkeeping must too
            if (wr_fire) begin
                ptr   <= ptr + 1'b1;
                count <= count_nx;
            end
            if (abort) begin
                state    <= ST_IDLE;
                op_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (load_start) begin
                            state <= ST_LOAD;
                            count <= '0;
                            ptr   <= '0;
                        end else if (run_start && count != '0) begin
                            state <= ST_RD_REQ;
                            ptr   <= '0;
                        end
                    end
                    ST_LOAD:    state <= (wr_valid && (wr_last || count_nx == FULL)) ? ST_IDLE : ST_LOAD;
                    ST_RD_REQ:  state <= ST_RD_WAIT;
                    ST_RD_WAIT: begin
                        op_data  <= mem_dout;
                        op_last  <= {1'b0, ptr} == count - 1'b1;
                        op_valid <= 1'b1;
                        state    <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (op_ready) begin
                            op_valid <= 1'b0;
                            state    <= (op_last && !LOOP) ? ST_IDLE : ST_RD_REQ;
                            ptr      <= op_last ? '0 : ptr + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_opmem_seq.sv
// tb_opmem_seq: directed checks of load, fetch, backpressure, loop, abort and async reset.
module tb_opmem_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_l = 1'b1;
    logic       load_start = 1'b0, wr_valid = 1'b0, wr_last = 1'b0, run_start = 1'b0, abort = 1'b0, op_ready = 1'b0;
    logic [7:0] wr_data = '0;

    logic       wr_ready, op_valid, op_last, busy, mem_ce, mem_oce, mem_wre;
    logic [7:0] op_data, mem_din, dout0;
    logic [3:0] count;
    logic [2:0] mem_ad;

    logic       wr_ready_l, op_valid_l, op_last_l, busy_l, mem_ce_l, mem_oce_l, mem_wre_l;
    logic [7:0] op_data_l, mem_din_l, dout1;
    logic [3:0] count_l;
    logic [2:0] mem_ad_l;

    logic [7:0] mem0 [8];
    logic [7:0] mem1 [8];
    logic [7:0] buf_b [8];
    logic [7:0] oq [$];
    logic       lq [$];
    logic [7:0] oq_l [$];
    logic       lq_l [$];
    int         ce_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    opmem_seq #(.ADDR_W(3), .DATA_W(8), .LOOP(1'b0)) dut (
        .clk(clk), .reset(rst), .load_start(load_start), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_last(wr_last), .wr_ready(wr_ready), .run_start(run_start), .abort(abort),
        .op_valid(op_valid), .op_data(op_data), .op_last(op_last), .op_ready(op_ready),
        .busy(busy), .count(count), .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre),
        .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(dout0)
    );

    opmem_seq #(.ADDR_W(3), .DATA_W(8), .LOOP(1'b1)) dut_l (
        .clk(clk), .reset(rst_l), .load_start(load_start), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_last(wr_last), .wr_ready(wr_ready_l), .run_start(run_start), .abort(abort),
        .op_valid(op_valid_l), .op_data(op_data_l), .op_last(op_last_l), .op_ready(op_ready),
        .busy(busy_l), .count(count_l), .mem_ce(mem_ce_l), .mem_oce(mem_oce_l), .mem_wre(mem_wre_l),
        .mem_ad(mem_ad_l), .mem_din(mem_din_l), .mem_dout(dout1)
    );

    // memory models plus handshake and enable monitors
    always @(posedge clk) begin
        if (op_valid && op_ready) begin
            oq.push_back(op_data);
            lq.push_back(op_last);
        end
        if (op_valid_l && op_ready) begin
            oq_l.push_back(op_data_l);
            lq_l.push_back(op_last_l);
        end
        if (mem_ce) begin
            ce_cnt++;
            if (mem_wre) mem0[mem_ad] <= mem_din;
            else dout0 <= mem0[mem_ad];
        end
        if (mem_ce_l) begin
            if (mem_wre_l) mem1[mem_ad_l] <= mem_din_l;
            else dout1 <= mem1[mem_ad_l];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int n, input bit last);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = buf_b[i];
            wr_last  = last && i == n - 1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic run(output int n);
        oq.delete();
        lq.delete();
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("run_timeout", n < 100, 1);
    endtask

    initial begin
        int n;
        int ce0;
        bit stable;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_mem_ce", mem_ce, 0);
        check("rst_mem_oce", mem_oce, 1);
        check("rst_wr_ready", wr_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) buf_b[i] = 8'h11 * (i + 1);
        load(5, 1'b1);
        check("ld5_count", count, 5);
        check("ld5_busy", busy, 0);
        for (int i = 0; i < 5; i++) check($sformatf("ld5_mem%0d", i), mem0[i], 8'h11 * (i + 1));
        op_ready = 1'b1;
        run(n);
        check("run5_cycles", n, 15);
        check("run5_len", oq.size(), 5);
        for (int i = 0; i < oq.size(); i++) begin
            check($sformatf("run5_op%0d", i), oq[i], 8'h11 * (i + 1));
            check($sformatf("run5_last%0d", i), lq[i], i == 4);
        end
        check("run5_busy", busy, 0);

        for (int i = 0; i < 8; i++) buf_b[i] = 8'hA0 + 8'(i);
        load(8, 1'b0);
        check("ld8_count", count, 8);
        check("ld8_busy", busy, 0);
        check("ld8_mem7", mem0[7], 8'hA7);
        wr_valid = 1'b1;
        #1;
        check("ld8_ninth_ready", wr_ready, 0);
        check("ld8_ninth_ce", mem_ce, 0);
        @(negedge clk);
        wr_valid = 1'b0;

        for (int i = 0; i < 5; i++) buf_b[i] = 8'h11 * (i + 1);
        load(5, 1'b1);
        oq.delete();
        lq.delete();
        op_ready = 1'b1;
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        n = 0;
        while (!(op_valid && op_data == 8'h33) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach", n < 50, 1);
        op_ready = 1'b0;
        ce0 = ce_cnt;
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            stable &= op_valid && op_data == 8'h33;
        end
        check("bp_stable", stable, 1);
        check("bp_no_ce", ce_cnt - ce0, 0);
        op_ready = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_len", oq.size(), 5);
        check("bp_op2", oq.size() > 2 ? oq[2] : 8'h00, 8'h33);
        check("bp_op4", oq.size() > 4 ? oq[4] : 8'h00, 8'h55);

        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("empty_count", count, 0);
        ce0 = ce_cnt;
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        check("empty_run_busy", busy, 0);
        @(negedge clk);
        check("empty_run_ce", ce_cnt - ce0, 0);
        load_start = 1'b1;
        run_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        run_start = 1'b0;
        check("both_wr_ready", wr_ready, 1);
        wr_valid = 1'b1;
        wr_data = 8'h5A;
        abort = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        abort = 1'b0;
        check("abort_wr_count", count, 1);
        check("abort_wr_busy", busy, 0);
        check("abort_wr_mem0", mem0[0], 8'h5A);

        rst_l = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) buf_b[i] = 8'(i + 1);
        load(3, 1'b1);
        check("loop_count", count_l, 3);
        oq_l.delete();
        lq_l.delete();
        op_ready = 1'b1;
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        n = 0;
        while (oq_l.size() < 5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        op_ready = 1'b0;
        check("loop_len", oq_l.size(), 5);
        for (int i = 0; i < oq_l.size(); i++) check($sformatf("loop_op%0d", i), oq_l[i], 8'((i % 3) + 1));
        check("loop_last2", lq_l.size() > 2 ? lq_l[2] : 1'b0, 1);
        n = 0;
        while (!op_valid_l && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("loop_hold_data", op_data_l, 8'h03);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("loop_abort_valid", op_valid_l, 0);
        check("loop_abort_busy", busy_l, 0);
        check("loop_abort_count", count_l, 3);
        check("loop_abort_ce", mem_ce_l, 0);

        op_ready = 1'b1;
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        repeat (3) @(negedge clk);
        check("ar_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_count", count, 0);
        check("ar_op_valid", op_valid, 0);
        check("ar_mem_ce", mem_ce, 0);
        check("ar_op_data", op_data, 0);
        @(negedge clk);
        rst = 1'b0;
        ce0 = ce_cnt;
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        check("ar_rerun_busy", busy, 0);
        @(negedge clk);
        check("ar_rerun_ce", ce_cnt - ce0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/opmem_seq.md
Name: opmem_seq

Overview:
- Initiator-side controller for the 8x8 single-port opcode memory: it drives the memory's ce/oce/wre/ad/din pins and consumes its dout.
- LOAD mode: accepts a byte stream from the host/loader and writes it into sequential addresses.
- RUN mode: reads the stored opcodes back in order and presents them to the core's decode stage over a valid/ready handshake.
- Owns the memory's one-cycle read latency and all port arbitration between loading and fetching.

Parameters:
- ADDR_W, 3, memory address width; DEPTH = 2**ADDR_W entries.
- DATA_W, 8, opcode width.
- LOOP, 0, 1 = RUN wraps from the last loaded entry back to address 0 until abort.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  pulse; clears count, enters LOAD.
- wr_valid  in  1  load byte valid.
- wr_data  in  DATA_W  load byte.
- wr_last  in  1  marks final load byte.
- wr_ready  out  1  load byte accepted when wr_valid&wr_ready.
- run_start  in  1  pulse; begins fetch from address 0.
- abort  in  1  pulse; returns to IDLE from any state.
- op_valid  out  1  op_data valid.
- op_data  out  DATA_W  fetched opcode.
- op_last  out  1  op_data is the final loaded entry.
- op_ready  in  1  consumer accepts op.
- busy  out  1  state != IDLE.
- count  out  ADDR_W+1  number of entries loaded, 0..DEPTH.
- mem_ce  out  1  memory clock enable.
- mem_oce  out  1  memory output enable; constant 1.
- mem_wre  out  1  memory write enable.
- mem_ad  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data; valid one clk after a read edge.

Behaviour:
- Reset values:
  - All outputs 0 except mem_oce = 1.
  - State IDLE; count = 0; internal address ptr = 0.
- States: IDLE, LOAD, RD_REQ, RD_WAIT, HOLD.
- IDLE:
  - load_start -> LOAD: count := 0, ptr := 0.
  - Else run_start with count != 0 -> RD_REQ: ptr := 0.
  - run_start with count == 0 is ignored.
  - load_start wins if both are asserted in the same cycle.
- LOAD:
  - wr_ready = 1 and is combinational from state.
  - Memory pins are combinational from the handshake: mem_ce = mem_wre = wr_valid, mem_ad = ptr, mem_din = wr_data.
  - Each accepted byte: ptr += 1, count += 1.
  - Exit to IDLE after accepting a byte with wr_last = 1, or after the DEPTH-th byte (count reaches DEPTH; a missing wr_last is tolerated).
  - run_start and load_start are ignored while in LOAD.
- RD_REQ:
  - One cycle with mem_ce = 1, mem_wre = 0, mem_ad = ptr.
  - Always -> RD_WAIT.
- RD_WAIT:
  - Capture mem_dout into op_data.
  - op_last := (ptr == count-1).
  - op_valid := 1; -> HOLD.
- HOLD:
  - op_valid, op_data and op_last are held stable until op_valid&op_ready.
  - On handshake, not last: ptr += 1, op_valid := 0, -> RD_REQ.
  - On handshake, last, LOOP=0: op_valid := 0, -> IDLE.
  - On handshake, last, LOOP=1: ptr := 0, op_valid := 0, -> RD_REQ.
- Throughput: 3 clk per opcode minimum, i.e. 3 cycles from RD_REQ entry to op_valid-low after an immediate op_ready.
- Outside LOAD and RD_REQ: mem_ce = 0, mem_wre = 0.
- abort:
  - From any state, next cycle: IDLE, op_valid = 0, memory idle.
  - count is preserved.
  - Any in-flight read data is discarded.
  - An abort arriving in the same cycle as a LOAD byte handshake still lets that write complete.
- Width rules:
  - ptr is ADDR_W bits and wraps naturally.
  - count is ADDR_W+1 bits and saturates at DEPTH.
- Asynchronous reset mid-operation: immediate return to reset values. Memory contents are not cleared.

Decomposition:
- Shared package gcore_pkg holds:
  - the state enum opmem_seq_state_t;
  - OPMEM_ADDR_W = 3 and OPMEM_DATA_W = 8.
- No sub-module. The FSM, pointer and output register fit in one module that instantiates nothing; the top level wires it to opmem.

Test Plan:
- Load 5 bytes 0x11,0x22,0x33,0x44,0x55, wr_last on 5th, then run_start with op_ready=1:
  - Writes land at addresses 0..4 and count = 5.
  - op_data sequence is 0x11..0x55 with op_last only on 0x55.
  - FSM ends in IDLE with busy = 0.
- Load 8 bytes 0xA0..0xA7 with no wr_last:
  - Auto-exit after the 8th byte with count = 8.
  - A 9th wr_valid sees wr_ready = 0.
- Backpressure: during RUN, hold op_ready = 0 for 4 clk on op 0x33:
  - op_data stays 0x33 with op_valid = 1 throughout.
  - No mem_ce asserts until the handshake.
- run_start with count = 0:
  - Stays IDLE; mem_ce never asserts.
  - load_start and run_start in the same cycle enters LOAD.
- LOOP = 1 with 3 bytes 0x01,0x02,0x03 loaded:
  - Output is 01,02,03,01,02 …
  - abort during HOLD gives op_valid = 0 and IDLE next clk with count = 3.
- Assert reset mid-RUN, asynchronously between edges:
  - Outputs go to their reset values at once and count = 0.
  - Re-running without reloading is ignored.
